// File: rtl/serial_to_parallel_8.sv
// Serial-to-parallel receiver: one bit per SEN cycle, MSB- or LSB-first per word, held output with valid/ack.
// Word appears on Q the same edge its last bit is sampled; an unacked Q drops the new word and sets sticky OVR.
module serial_to_parallel_8 #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             CP,
   input  logic             CR,
   input  logic             SIN,
   input  logic             SEN,
   input  logic             DIR,
   input  logic             SYNC,
   input  logic             Q_ACK,
   input  logic             CLR_OVR,
   output logic [WIDTH-1:0] Q,
   output logic             Q_VALID,
   output logic             OVR,
   output logic             BUSY,
   output logic [CNT_W-1:0] BCNT
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n, shifted, q_n;
   logic [CNT_W-1:0] bcnt_n;
   logic             dir_l, dir_n, shift_dir;
   logic             q_valid_n, ovr_n;

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         state   <= IDLE;
         shreg   <= '0;
         BCNT    <= '0;
         dir_l   <= 1'b0;
         Q       <= '0;
         Q_VALID <= 1'b0;
         OVR     <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         BCNT    <= bcnt_n;
         dir_l   <= dir_n;
         Q       <= q_n;
         Q_VALID <= q_valid_n;
         OVR     <= ovr_n;
      end
   end

   // A bit that starts a word (from IDLE or via SYNC) uses the live DIR, not the latched one.
   always_comb begin
      shift_dir = (state == IDLE || SYNC) ? DIR : dir_l;
      shifted   = shift_dir ? {shreg[WIDTH-2:0], SIN} : {SIN, shreg[WIDTH-1:1]};
   end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bcnt_n    = BCNT;
      dir_n     = dir_l;
      q_n       = Q;
      q_valid_n = Q_VALID;
      ovr_n     = OVR;

      if (Q_ACK && Q_VALID) q_valid_n = 1'b0;
      if (CLR_OVR)          ovr_n     = 1'b0;

      if (SYNC) begin
         if (SEN) begin
            dir_n   = DIR;
            shreg_n = shifted;
            bcnt_n  = CNT_W'(1);
            state_n = SHIFT;
         end else begin
            bcnt_n  = '0;
            state_n = IDLE;
         end
      end else if (SEN) begin
         shreg_n = shifted;
         if (state == IDLE) begin
            dir_n   = DIR;
            bcnt_n  = CNT_W'(1);
            state_n = SHIFT;
         end else if (BCNT == CNT_W'(WIDTH - 1)) begin
            bcnt_n  = '0;
            state_n = IDLE;
            // Overrun set wins over a same-edge CLR_OVR.
            if (!Q_VALID || Q_ACK) begin
               q_n       = shifted;
               q_valid_n = 1'b1;
            end else begin
               ovr_n = 1'b1;
            end
         end else begin
            bcnt_n = BCNT + CNT_W'(1);
         end
      end
   end

   assign BUSY = (state == SHIFT);

endmodule

// File: tb/tb_serial_to_parallel_8.sv
// Self-checking bench for serial_to_parallel_8: scoreboard of completed words plus a small handshake/overrun model.
module tb_serial_to_parallel_8;

   logic       CP = 1'b0;
   logic       CR, SIN, SEN, DIR, SYNC, Q_ACK, CLR_OVR;
   logic [7:0] Q;
   logic       Q_VALID, OVR, BUSY;
   logic [2:0] BCNT;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] sb_q[$];
   logic [7:0] m_q;
   logic       m_qv, m_ovr;
   logic       clr_on_last;

   serial_to_parallel_8 #(.WIDTH(8), .CNT_W(3)) dut (
      .CP(CP), .CR(CR), .SIN(SIN), .SEN(SEN), .DIR(DIR), .SYNC(SYNC),
      .Q_ACK(Q_ACK), .CLR_OVR(CLR_OVR), .Q(Q), .Q_VALID(Q_VALID),
      .OVR(OVR), .BUSY(BUSY), .BCNT(BCNT)
   );

   always #5 CP = ~CP;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " Q"},       int'(Q),       int'(m_q));
      check({tag, " Q_VALID"}, int'(Q_VALID), int'(m_qv));
      check({tag, " OVR"},     int'(OVR),     int'(m_ovr));
   endtask

   // Feeds the first n bits of w; DIR is inverted after the first bit to prove it is latched.
   task automatic send_partial(input logic [7:0] w, input logic dir, input int n);
      for (int i = 0; i < n; i++) begin
         DIR = (i == 0) ? dir : ~dir;
         SIN = dir ? w[7-i] : w[i];
         SEN = 1'b1;
         tick();
         check("partial BCNT", int'(BCNT), i + 1);
      end
      SEN = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input logic dir, input logic ack_last,
                            input int gap_after, input logic sync_first);
      logic [7:0] exp;
      for (int i = 0; i < 8; i++) begin
         DIR   = (i == 0) ? dir : ~dir;
         SIN   = dir ? w[7-i] : w[i];
         SEN   = 1'b1;
         SYNC  = sync_first && (i == 0);
         Q_ACK = (i == 7) ? ack_last : 1'b0;
         if (i == 7) begin
            CLR_OVR = clr_on_last;
            if (!m_qv || ack_last) begin
               m_q  = w;
               m_qv = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
            if (clr_on_last && !(m_qv && !ack_last && m_q != w)) m_ovr = m_ovr;
            sb_q.push_back(m_q);
         end
         tick();
         SYNC = 1'b0;
         if (i < 7) begin
            check("word BCNT", int'(BCNT), i + 1);
            check("word BUSY", int'(BUSY), 1);
         end
         if (gap_after != 0 && i == gap_after - 1) begin
            for (int g = 0; g < 3; g++) begin
               SEN = 1'b0;
               SIN = 1'($urandom_range(0, 1));
               DIR = 1'($urandom_range(0, 1));
               tick();
               check("gap BCNT", int'(BCNT), gap_after);
               check("gap BUSY", int'(BUSY), 1);
            end
         end
      end
      SEN = 1'b0; Q_ACK = 1'b0; CLR_OVR = 1'b0;
      exp = sb_q.pop_front();
      check("done Q",       int'(Q),       int'(exp));
      check("done Q_VALID", int'(Q_VALID), int'(m_qv));
      check("done OVR",     int'(OVR),     int'(m_ovr));
      check("done BCNT",    int'(BCNT),    0);
      check("done BUSY",    int'(BUSY),    0);
   endtask

   task automatic do_ack();
      Q_ACK = 1'b1;
      tick();
      Q_ACK = 1'b0;
      m_qv  = 1'b0;
      check_outputs("ack");
   endtask

   task automatic do_clear();
      CLR_OVR = 1'b1;
      tick();
      CLR_OVR = 1'b0;
      m_ovr   = 1'b0;
      check_outputs("clr");
   endtask

   initial begin
      CR = 1'b1; SIN = 1'b0; SEN = 1'b0; DIR = 1'b0; SYNC = 1'b0;
      Q_ACK = 1'b0; CLR_OVR = 1'b0; clr_on_last = 1'b0;
      m_q = 8'h00; m_qv = 1'b0; m_ovr = 1'b0;
      repeat (2) tick();
      CR = 1'b0;
      tick();
      check_outputs("reset");
      check("reset BCNT", int'(BCNT), 0);
      check("reset BUSY", int'(BUSY), 0);

      // Ack while nothing valid is ignored.
      do_ack();

      // 1: MSB-first 8'h80
      send_word(8'h80, 1'b1, 1'b0, 0, 1'b0);
      do_ack();

      // 2: LSB-first loopback of 8'hA5
      send_word(8'hA5, 1'b0, 1'b0, 0, 1'b0);
      do_ack();

      // 3: gapped MSB-first 8'h3C
      send_word(8'h3C, 1'b1, 1'b0, 4, 1'b0);
      do_ack();

      // 4: overrun, ack on completion edge, clear, then set-beats-clear
      send_word(8'h11, 1'b1, 1'b0, 0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0, 0, 1'b0);
      send_word(8'h33, 1'b1, 1'b1, 0, 1'b0);
      do_clear();
      clr_on_last = 1'b1;
      send_word(8'h44, 1'b0, 1'b0, 0, 1'b0);
      clr_on_last = 1'b0;
      do_clear();

      // 5: SYNC without SEN after 5 bits, then C3; then SYNC with SEN starting 8'h96
      send_partial(8'hFF, 1'b1, 5);
      SYNC = 1'b1;
      tick();
      SYNC = 1'b0;
      check("sync BCNT", int'(BCNT), 0);
      check("sync BUSY", int'(BUSY), 0);
      check_outputs("sync");
      send_word(8'hC3, 1'b1, 1'b1, 0, 1'b0);
      send_partial(8'h0F, 1'b0, 3);
      send_word(8'h96, 1'b0, 1'b1, 0, 1'b1);

      // 6: async reset mid-word while Q_VALID=1 and OVR=1
      send_word(8'h77, 1'b1, 1'b0, 0, 1'b0);
      send_partial(8'hAA, 1'b1, 6);
      @(negedge CP);
      #1 CR = 1'b1;
      #1;
      m_q = 8'h00; m_qv = 1'b0; m_ovr = 1'b0;
      check_outputs("async rst");
      check("async rst BCNT", int'(BCNT), 0);
      check("async rst BUSY", int'(BUSY), 0);
      CR = 1'b0;
      send_word(8'h5A, 1'b1, 1'b0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
